// File: rtl/fpga_cfg_pkg.sv
// Shared types and header layout for the FPGA configuration loader.
// FPGA_CFG_CHKSUM_EN adds the trailing-checksum state.
package fpga_cfg_pkg;

  localparam logic [7:0] CFG_SYNC = 8'hA5;

  // Header word bit positions
  localparam int unsigned HdrSyncLsb  = 24;
  localparam int unsigned HdrRsvdBit  = 23;
  localparam int unsigned HdrMaskLsb  = 16;
  localparam int unsigned HdrCountLsb = 0;
  localparam int unsigned HdrMaskW    = 7;
  localparam int unsigned HdrCountW   = 16;

  typedef struct packed {
    logic [7:0]           sync;
    logic                 rsvd;
    logic [HdrMaskW-1:0]  mask;
    logic [HdrCountW-1:0] count;
  } cfg_hdr_t;

  typedef enum logic [1:0] {
    HdrData,
    HdrEnd,
    HdrErr
  } hdr_class_e;

  typedef enum logic [2:0] {
    StIdle,
    StPayload,
`ifdef FPGA_CFG_CHKSUM_EN
    StChk,
`endif
    StGap,
    StDone,
    StErr
  } cfg_state_e;

endpackage

// File: rtl/fpga_cfg_hdr_dec.sv
// Combinational header decoder: classifies a header word as data frame, end frame
// or protocol error, and extracts the chain mask and word count.
module fpga_cfg_hdr_dec
  import fpga_cfg_pkg::*;
(
  input  logic [31:0]          hdr_i,
  output hdr_class_e           class_o,
  output logic [HdrMaskW-1:0]  mask_o,
  output logic [HdrCountW-1:0] count_o
);

  cfg_hdr_t hdr;
  logic     mask_onehot;
  logic     count_zero;

  assign hdr.sync  = hdr_i[HdrSyncLsb +: 8];
  assign hdr.rsvd  = hdr_i[HdrRsvdBit];
  assign hdr.mask  = hdr_i[HdrMaskLsb +: HdrMaskW];
  assign hdr.count = hdr_i[HdrCountLsb +: HdrCountW];

  assign mask_onehot = (hdr.mask != '0) && ((hdr.mask & (hdr.mask - 7'd1)) == '0);
  assign count_zero  = (hdr.count == '0);

  assign mask_o  = hdr.mask;
  assign count_o = hdr.count;

  always_comb begin
    class_o = HdrErr;
    if ((hdr.sync == CFG_SYNC) && !hdr.rsvd) begin
      if (mask_onehot && !count_zero) begin
        class_o = HdrData;
      end else if ((hdr.mask == '0) && count_zero) begin
        class_o = HdrEnd;
      end
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Bitstream loader: accepts framed words over valid/ready and shifts payload into the
// selected fabric config chain. FPGA_CFG_CHKSUM_EN enables the per-frame XOR checksum word.
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned CHAINS = 7,
  parameter int unsigned GAP    = 2
) (
  input  logic              clk,
  input  logic              nres,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic [DW-1:0]     prog_i,
  output logic [CHAINS-1:0] prog_shft,
  output logic              data_en,
  output logic              busy,
  output logic              err
);

  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

  cfg_state_e            state_q;
  logic [HdrCountW-1:0]  cnt_q;
  logic [GapW-1:0]       gap_q;
  logic [CHAINS-1:0]     mask_q;
`ifdef FPGA_CFG_CHKSUM_EN
  logic [DW-1:0]         chk_q;
`endif

  hdr_class_e            hdr_class;
  logic [HdrMaskW-1:0]   hdr_mask;
  logic [HdrCountW-1:0]  hdr_count;
  logic                  accept;

  fpga_cfg_hdr_dec u_hdr_dec (
    .hdr_i   (s_data[31:0]),
    .class_o (hdr_class),
    .mask_o  (hdr_mask),
    .count_o (hdr_count)
  );

  assign accept = s_valid && s_ready;

  // All outputs are registered; prog_shft defaults to zero so each accept gives one shift.
  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      gap_q     <= '0;
      mask_q    <= '0;
`ifdef FPGA_CFG_CHKSUM_EN
      chk_q     <= '0;
`endif
      s_ready   <= 1'b0;
      prog_i    <= '0;
      prog_shft <= '0;
      data_en   <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      prog_shft <= '0;
      unique case (state_q)
        StIdle: begin
          s_ready <= 1'b1;
          if (accept) begin
            unique case (hdr_class)
              HdrData: begin
                state_q <= StPayload;
                mask_q  <= CHAINS'(hdr_mask);
                cnt_q   <= hdr_count;
                busy    <= 1'b1;
`ifdef FPGA_CFG_CHKSUM_EN
                chk_q   <= '0;
`endif
              end
              HdrEnd: begin
                state_q <= StDone;
                s_ready <= 1'b0;
                data_en <= 1'b1;
              end
              default: begin
                state_q <= StErr;
                s_ready <= 1'b0;
                err     <= 1'b1;
              end
            endcase
          end
        end
        StPayload: begin
          if (accept) begin
            prog_i    <= s_data;
            prog_shft <= mask_q;
            cnt_q     <= cnt_q - 16'd1;
`ifdef FPGA_CFG_CHKSUM_EN
            chk_q     <= chk_q ^ s_data;
            if (cnt_q == 16'd1) begin
              state_q <= StChk;
            end
`else
            if (cnt_q == 16'd1) begin
              state_q <= StGap;
              s_ready <= 1'b0;
              gap_q   <= GapW'(GAP - 1);
            end
`endif
          end
        end
`ifdef FPGA_CFG_CHKSUM_EN
        StChk: begin
          if (accept) begin
            s_ready <= 1'b0;
            if (s_data == chk_q) begin
              state_q <= StGap;
              gap_q   <= GapW'(GAP - 1);
            end else begin
              state_q <= StErr;
              busy    <= 1'b0;
              err     <= 1'b1;
            end
          end
        end
`endif
        StGap: begin
          if (gap_q == '0) begin
            state_q <= StIdle;
            s_ready <= 1'b1;
            busy    <= 1'b0;
          end else begin
            gap_q <= gap_q - GapW'(1);
          end
        end
        StDone: begin
          s_ready <= 1'b0;
          data_en <= 1'b1;
        end
        StErr: begin
          s_ready <= 1'b0;
          err     <= 1'b1;
        end
        default: begin
          state_q <= StErr;
          s_ready <= 1'b0;
          err     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed self-checking bench for fpga_cfg_loader; honours FPGA_CFG_CHKSUM_EN.
module tb_fpga_cfg_loader;

  logic        clk = 1'b0;
  logic        nres = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = '0;
  logic [31:0] prog_i;
  logic [6:0]  prog_shft;
  logic        data_en;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int shift_cnt = 0;

  fpga_cfg_loader #(
    .DW     (32),
    .CHAINS (7),
    .GAP    (2)
  ) dut (
    .clk       (clk),
    .nres      (nres),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .prog_i    (prog_i),
    .prog_shft (prog_shft),
    .data_en   (data_en),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (prog_shft != '0) shift_cnt <= shift_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns #1 after the accepting edge, i.e. in the cycle that shows the word's effect.
  task automatic push(input logic [31:0] w);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = w;
    while (s_ready !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_timeout", {63'd0, n < 200}, 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic finish_frame(input logic [31:0] x);
`ifdef FPGA_CFG_CHKSUM_EN
    push(x);
`else
    if (x === 32'hx) $display("unused");
`endif
  endtask

  task automatic do_reset();
    s_valid = 1'b0;
    nres = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nres = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] w;
    logic [31:0] hdr;
    logic [31:0] x;
    logic [31:0] err_hdrs [3];
    int base;

    // Reset state
    #1;
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    chk("rst_prog_i", {32'd0, prog_i}, 64'd0);
    chk("rst_prog_shft", {57'd0, prog_shft}, 64'd0);
    chk("rst_flags", {61'd0, data_en, busy, err}, 64'd0);
    do_reset();
    chk("ready_before_edge", {63'd0, s_ready}, 64'd0);
    cycle();
    chk("ready_after_release", {63'd0, s_ready}, 64'd1);

    // Basic 3-word frame on chain 0
    push(32'hA501_0003);
    chk("hdr_no_shift", {57'd0, prog_shft}, 64'd0);
    chk("hdr_busy", {63'd0, busy}, 64'd1);
    for (int i = 1; i <= 3; i++) begin
      push(32'(i));
      chk("b_shft", {57'd0, prog_shft}, 64'h01);
      chk("b_prog_i", {32'd0, prog_i}, 64'(i));
    end
    finish_frame(32'h0000_0000);
    chk("gap1_ready", {63'd0, s_ready}, 64'd0);
    cycle();
    chk("gap2_shft", {57'd0, prog_shft}, 64'd0);
    chk("gap2_ready_busy", {62'd0, s_ready, busy}, 64'b01);
    cycle();
    chk("idle_shft", {57'd0, prog_shft}, 64'd0);
    chk("idle_ready_busy", {62'd0, s_ready, busy}, 64'b10);

    // All seven chains, 8 words each, then end frame
    for (int c = 0; c < 7; c++) begin
      hdr = 32'hA500_0008 | (32'(1) << (16 + c));
      push(hdr);
      x = '0;
      for (int k = 0; k < 8; k++) begin
        w = 32'hF000_0000 >> (4 * k);
        x = x ^ w;
        push(w);
        chk("chain_shft", {57'd0, prog_shft}, 64'(1 << c));
        chk("chain_word", {32'd0, prog_i}, {32'd0, w});
      end
      finish_frame(x);
    end
    push(32'hA500_0000);
    chk("end_data_en", {63'd0, data_en}, 64'd1);
    chk("end_ready", {63'd0, s_ready}, 64'd0);
    repeat (3) cycle();
    chk("end_data_en_hold", {62'd0, data_en, s_ready}, 64'b10);

    // Stall mid-payload
    do_reset();
    base = shift_cnt;
    push(32'hA504_0003);
    push(32'h0000_0011);
    chk("st_w1", {25'd0, prog_shft, prog_i}, {25'd0, 7'h04, 32'h11});
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("st_stall", {25'd0, prog_shft, prog_i}, {25'd0, 7'h00, 32'h11});
    end
    push(32'h0000_0022);
    chk("st_w2", {25'd0, prog_shft, prog_i}, {25'd0, 7'h04, 32'h22});
    push(32'h0000_0033);
    finish_frame(32'h0000_0000);
    repeat (3) cycle();
    chk("st_shift_total", 64'(shift_cnt - base), 64'd3);

    // Error headers
    err_hdrs[0] = 32'h5A01_0001;
    err_hdrs[1] = 32'hA503_0001;
    err_hdrs[2] = 32'hA501_0000;
    for (int e = 0; e < 3; e++) begin
      do_reset();
      base = shift_cnt;
      push(err_hdrs[e]);
      chk("err_flag", {62'd0, err, s_ready}, 64'b10);
      repeat (3) cycle();
      chk("err_hold", {61'd0, err, s_ready, busy}, 64'b100);
      chk("err_no_shift", 64'(shift_cnt - base), 64'd0);
    end
    do_reset();
    push(32'hA581_0001);
    chk("err_rsvd", {62'd0, err, s_ready}, 64'b10);

    // Reset mid-frame
    do_reset();
    push(32'hA508_0004);
    push(32'h0000_0001);
    chk("mr_w1", {57'd0, prog_shft}, 64'h08);
    s_valid = 1'b1;
    s_data  = 32'h0000_0002;
    #2;
    nres = 1'b0;
    #1;
    chk("mr_cleared", {25'd0, prog_shft, prog_i, s_ready, data_en, busy, err}, 64'd0);
    s_valid = 1'b0;
    cycle();
    nres = 1'b1;
    push(32'hA510_0002);
    push(32'h0000_00AA);
    chk("mr_new1", {25'd0, prog_shft, prog_i}, {25'd0, 7'h10, 32'hAA});
    push(32'h0000_00BB);
    chk("mr_new2", {25'd0, prog_shft, prog_i}, {25'd0, 7'h10, 32'hBB});
    finish_frame(32'h0000_0011);
    repeat (3) cycle();
    chk("mr_idle", {61'd0, s_ready, busy, err}, 64'b100);

`ifdef FPGA_CFG_CHKSUM_EN
    // Checksum match and mismatch
    do_reset();
    push(32'hA502_0002);
    push(32'd3);
    push(32'd5);
    push(32'd6);
    chk("ck_ok_err", {63'd0, err}, 64'd0);
    repeat (3) cycle();
    chk("ck_ok_idle", {62'd0, s_ready, err}, 64'b10);
    do_reset();
    base = shift_cnt;
    push(32'hA502_0002);
    push(32'd3);
    push(32'd5);
    push(32'd7);
    chk("ck_bad_err", {62'd0, err, s_ready}, 64'b10);
    cycle();
    chk("ck_bad_shifts", 64'(shift_cnt - base), 64'd2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fpga_cfg_loader.md
# fpga_cfg_loader

Hardware bitstream loader that drives the programming port of the `fpga` fabric, replacing bench-driven `prog_i`/`prog_shft` sequences. It accepts a framed 32-bit word stream over a valid/ready interface, then shifts each payload word into the selected configuration chain. When the end-of-configuration frame arrives, it raises `data_en` to release the fabric. The block sits between the system-side config source (SPI/flash reader, host bus FIFO) and `fpga`.

## Interface
- `DW`, 32: payload/prog word width; equals `fpga` `prog_i` width.
- `CHAINS`, 7: number of config chains; equals `prog_shft` width.
- `GAP`, 2: minimum idle cycles with `prog_shft==0` between frames (≥1).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `nres` in 1: reset, asynchronous assert, active-low.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: loader can accept a word.
- `s_data` in DW: input word.
- `prog_i` out DW: config word to fabric.
- `prog_shft` out CHAINS: one-hot chain shift enable, 0 = no shift.
- `data_en` out 1: configuration complete; fabric enabled.
- `busy` out 1: frame in progress (PAYLOAD or GAP).
- `err` out 1: protocol error latched.

## Operation
- Header word fields: [31:24] sync = 8'hA5; [23] reserved, must be 0; [22:16] chain mask; [15:0] word count N.
- Data frame: header with one-hot mask and N≥1, followed by N payload words.
- End frame: header with mask = 0 and N = 0. Enters DONE.
- States:
  - IDLE: `s_ready`=1. A valid header moves to PAYLOAD with cnt=N. An end frame moves to DONE. Anything else moves to ERR.
  - PAYLOAD: `s_ready`=1. Each accepted word decrements cnt. The last word moves to GAP.
  - GAP: `s_ready`=0 for GAP cycles, then IDLE.
  - DONE: `s_ready`=0, `data_en`=1. Terminal until reset.
  - ERR: `s_ready`=0, `err`=1. Terminal until reset.
- Error conditions: bad sync; reserved bit set; mask not one-hot and nonzero; mask one-hot with N=0; mask 0 with N≠0.
- Stall in PAYLOAD (`s_valid`=0): `prog_shft`=0 that cycle and `prog_i` holds its value. No shift occurs and no timeout applies.
- The header word itself is never presented on `prog_i`.
- Counter is 16 bits. N=65535 is legal. No wrap occurs because the exit is on cnt==1 at accept.

## Timing
- Reset values: `s_ready`=0, `prog_i`=0, `prog_shft`=0, `data_en`=0, `busy`=0, `err`=0. State = IDLE.
- `s_ready` rises in the first cycle after `nres` deasserts.
- Payload accepted on edge t drives `prog_i`=word and `prog_shft`=mask during cycle t+1. Each accepted word produces exactly one shift cycle.
- The last payload word's shift cycle is followed by GAP cycles with `prog_shft`=0. The next header is accepted at the earliest on the edge ending the last GAP cycle.
- `data_en` rises one cycle after the end-frame header is accepted.
- `err` rises one cycle after the offending word is accepted. Chains already shifted are not undone.
- `busy` is registered, high from the cycle after header accept through the last GAP cycle.
- Reset mid-frame clears all outputs asynchronously. Fabric chain contents are not touched by this block.

## Configuration
- `FPGA_CFG_CHKSUM_EN` defined:
  - Each data frame carries one trailing word after the N payload words. This word equals the XOR of all N payload words.
  - The trailing word is consumed in a CHK state with `prog_shft`=0. A mismatch moves to ERR; a match moves to GAP.
- Undefined: no trailing word, and there is no CHK state.

## Structure
- Package `fpga_cfg_pkg` holds:
  - the state enum;
  - `CFG_SYNC` = 8'hA5;
  - header field bit positions;
  - the header struct (sync, rsvd, mask, count).
- One sub-module, `fpga_cfg_hdr_dec`. It is combinational: it decodes a header into a class (data, end, error) plus mask and count.
- FSM, counters and output registers live in the top module.

## Test plan
- Reset, then header 32'hA5010003 and words 1, 2, 3 back-to-back.
  - `prog_shft`=7'h01 for 3 consecutive cycles with `prog_i`=1, 2, 3.
  - Then 2 cycles of 0, then `s_ready`=1.
- All seven chains, each with 8 words F0000000…0000000F using masks 01…40, then end frame 32'hA5000000.
  - Chain programming matches the manual bench sequence.
  - `data_en`=1 one cycle after the end frame is accepted and stays high.
- Stall mid-payload: `s_valid` low for 3 cycles between word 1 and word 2.
  - `prog_shft`=0 during the stall.
  - Exactly N shift cycles in total.
- Error headers 32'h5A010001, 32'hA5030001 and 32'hA5010000, each from reset.
  - `err`=1 and `s_ready`=0 thereafter.
  - `prog_shft` never nonzero.
- `nres` pulsed low during the 2nd word of a 4-word frame.
  - All outputs go to 0 immediately.
  - After release, a new frame loads correctly.
- With `FPGA_CFG_CHKSUM_EN`, frame 32'hA5020002, words 3, 5, checksum 6: accepted.
  - Checksum 7 instead: `err`=1 after the checksum word, with only 2 shift cycles seen.
